// File: rtl/od_ex_skid_stage.sv
// Operand-decode to execute pipeline boundary: a 2-entry skid buffer with a registered in_ready,
// plus the forwarded-operand register for OD1 and a saturating back-pressure counter.
module od_ex_skid_stage #(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 8,
    parameter int CTRL_W  = 6,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_op1,
    input  logic [DATA_W-1:0]  in_op2,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [CTRL_W-1:0]  in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_op1,
    output logic [DATA_W-1:0]  out_op2,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CTRL_W-1:0]  out_ctrl,
    input  logic               wb_load,
    input  logic [DATA_W-1:0]  wb_data,
    output logic [DATA_W-1:0]  fwd_data,
    output logic               fwd_valid,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int ENT_W = 2 * DATA_W + INSTR_W + CTRL_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ENT_W-1:0]   main_q;
    logic [ENT_W-1:0]   main_nxt;
    logic [ENT_W-1:0]   skid_q;
    logic [ENT_W-1:0]   skid_nxt;
    logic [ENT_W-1:0]   in_ent;
    logic               in_ready_q;
    logic               accept;
    logic               pop;
    logic [DATA_W-1:0]  fwd_q;
    logic               fwd_valid_q;
    logic [CNT_W-1:0]   stall_q;

    // Valid/ready: a beat moves on a rising edge where valid and ready are both high; the
    // producer holds its beat until then and the buffer never alters a held entry.
    assign in_ent    = {in_op1, in_op2, in_instr, in_ctrl};
    assign accept    = in_valid & in_ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign pop       = out_valid & out_ready;
    assign in_ready  = in_ready_q;

    assign {out_op1, out_op2, out_instr, out_ctrl} = main_q;
    assign fwd_data  = fwd_q;
    assign fwd_valid = fwd_valid_q;
    assign stall_cnt = stall_q;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            // Zeroing on flush keeps out_* clean while out_valid is low.
            state_nxt = ST_EMPTY;
            main_nxt  = '0;
            skid_nxt  = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt = ST_ONE;
                        main_nxt  = in_ent;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_nxt = in_ent;
                    end else if (accept) begin
                        state_nxt = ST_TWO;
                        skid_nxt  = in_ent;
                    end else if (pop) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        state_nxt = ST_ONE;
                        main_nxt  = skid_q;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            main_q     <= main_nxt;
            skid_q     <= skid_nxt;
            in_ready_q <= (state_nxt != ST_TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fwd_q       <= '0;
            fwd_valid_q <= 1'b0;
        end else if (wb_load) begin
            fwd_q       <= wb_data;
            fwd_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_od_ex_skid_stage.sv
// Randomised and directed bench for od_ex_skid_stage; a queue-based FIFO model predicts every
// output and the scoreboard process compares it on the falling edge.
module tb_od_ex_skid_stage;

    localparam int ENT_W = 30;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_op1;
    logic [7:0] in_op2;
    logic [7:0] in_instr;
    logic [5:0] in_ctrl;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_op1;
    logic [7:0] out_op2;
    logic [7:0] out_instr;
    logic [5:0] out_ctrl;
    logic       wb_load;
    logic [7:0] wb_data;
    logic [7:0] fwd_data;
    logic       fwd_valid;
    logic [7:0] stall_cnt;

    od_ex_skid_stage #(
        .DATA_W(8), .INSTR_W(8), .CTRL_W(6), .CNT_W(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_instr(in_instr), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_instr(out_instr), .out_ctrl(out_ctrl),
        .wb_load(wb_load), .wb_data(wb_data),
        .fwd_data(fwd_data), .fwd_valid(fwd_valid), .stall_cnt(stall_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state: the FIFO contents in order, plus side registers
    logic [ENT_W-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    int               stall_m  = 0;
    logic [7:0]       fwd_m    = 8'h00;
    logic             fwdv_m   = 1'b0;
    logic             zero_m   = 1'b1;
    logic             armed    = 1'b0;
    int               sz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // scoreboard: compare current outputs, then advance the model by this cycle's inputs
    always @(negedge clk) begin
        if (armed) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
            check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
            check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
            check("fwd_data", 32'(fwd_data), 32'(fwd_m));
            check("fwd_valid", 32'(fwd_valid), 32'(fwdv_m));
            if (exp_q.size() > 0)
                check("out_entry", 32'({out_op1, out_op2, out_instr, out_ctrl}), 32'(exp_q[0]));
            else if (zero_m)
                check("out_zero", 32'({out_op1, out_op2, out_instr, out_ctrl}), 32'h0);
        end
        if (!reset_n) begin
            exp_q.delete();
            stall_m = 0;
            fwd_m   = 8'h00;
            fwdv_m  = 1'b0;
            zero_m  = 1'b1;
            armed   = 1'b1;
        end else if (armed) begin
            sz = exp_q.size();
            if (sz > 0 && !out_ready && stall_m < 255) stall_m++;
            if (wb_load) begin
                fwd_m  = wb_data;
                fwdv_m = 1'b1;
            end
            if (sz > 0 && out_ready) void'(exp_q.pop_front());
            if (flush) begin
                exp_q.delete();
                zero_m = 1'b1;
            end else if (in_valid && sz < 2) begin
                exp_q.push_back({in_op1, in_op2, in_instr, in_ctrl});
                zero_m = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [7:0] op1);
        in_op1   = op1;
        in_op2   = 8'($urandom);
        in_instr = 8'($urandom);
        in_ctrl  = 6'($urandom);
    endtask

    task automatic quiet();
        in_valid = 1'b0;
        flush    = 1'b0;
        wb_load  = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b0;
        wb_data   = 8'h00;
        quiet();
        set_in(8'h00);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // streaming 0x11..0x15
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(8'(8'h11 + i));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();

        // backpressure into TWO, then drain
        out_ready = 1'b0;
        set_in(8'hA1); in_valid = 1'b1; tick();
        set_in(8'hA2); tick();
        in_valid = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
        repeat (3) tick();

        // flush while full with an offered 0x3C instruction
        out_ready = 1'b0;
        set_in(8'hB1); in_valid = 1'b1; tick();
        set_in(8'hB2); tick();
        set_in(8'hB3); in_instr = 8'h3C; flush = 1'b1; tick();
        quiet();
        repeat (2) tick();

        // flush in ONE with simultaneous accept and pop
        out_ready = 1'b1;
        set_in(8'hC1); in_valid = 1'b1; tick();
        set_in(8'hC2); flush = 1'b1; tick();
        quiet();
        repeat (2) tick();

        // forwarding register survives a flush
        wb_load = 1'b1; wb_data = 8'h5E; tick();
        wb_load = 1'b0; wb_data = 8'($urandom); tick();
        flush = 1'b1; tick();
        flush = 1'b0;
        repeat (2) tick();

        // random traffic
        repeat (400) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            wb_load   = ($urandom_range(0, 3) == 0);
            wb_data   = 8'($urandom);
            set_in(8'($urandom));
            tick();
        end
        quiet();
        out_ready = 1'b1;
        repeat (3) tick();

        // stall counter saturation
        out_ready = 1'b0;
        set_in(8'hD1); in_valid = 1'b1; tick();
        in_valid = 1'b0;
        repeat (300) tick();
        out_ready = 1'b1;
        repeat (3) tick();

        // reset in TWO with a valid forwarded value; reset beats flush/wb_load/accept
        out_ready = 1'b0;
        wb_load = 1'b1; wb_data = 8'($urandom);
        set_in(8'hE1); in_valid = 1'b1; tick();
        wb_load = 1'b0;
        set_in(8'hE2); tick();
        set_in(8'hE3); tick();
        reset_n = 1'b0; flush = 1'b1; wb_load = 1'b1; tick();
        reset_n = 1'b1;
        quiet();
        repeat (3) tick();
        out_ready = 1'b1;
        set_in(8'hF1); in_valid = 1'b1; tick();
        quiet();
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
